decoder_scan_n: RTL

//   Parametrised, registered N-to-2^N one-hot decoder for switch-to-LED lab panels.

---
 rtl/decoder_scan_n.sv | 92 +++++++++
 1 files changed

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - debounced, registered N-to-2^N one-hot decoder with LED chaser scan mode
module decoder_scan_n #(
    parameter int SEL_W      = 3,
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid
);
    localparam int OUT_N = 2 ** SEL_W;
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    logic [SEL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] commit_q, commit_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             scan_q, scan_d;
    logic             valid_q, valid_d;
    logic [OUT_N-1:0] y_q, y_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_d = commit_q;
        // Debounce ignores en/mode so the committed value is always current.
        if (sel != cand_q) begin
            cand_d = sel;
            cnt_d  = '0;
        end else if (cnt_q != CNT_W'(DEB_CYCLES - 1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            commit_d = cand_q;
        end

        idx_d   = idx_q;
        pre_d   = pre_q;
        scan_d  = en & mode;
        valid_d = en;
        if (en) begin
            if (!mode) begin
                idx_d = commit_q;
                pre_d = '0;
            end else if (!scan_q) begin
                // First scan cycle after entry or re-enable: hold idx, restart the step.
                pre_d = '0;
            end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        y_d = en ? ((OUT_N'(1) << idx_d) ^ INACTIVE) : INACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            commit_q <= '0;
            idx_q    <= '0;
            pre_q    <= '0;
            scan_q   <= 1'b0;
            valid_q  <= 1'b0;
            y_q      <= INACTIVE;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            scan_q   <= scan_d;
            valid_q  <= valid_d;
            y_q      <= y_d;
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
endmodule
